// File: rtl/manycore_credit_hold_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : manycore_credit_hold_unit
// Brief   : Saturating outgoing-credit counter plus a one-cycle return-data
//           hold stage. Optional checks: MANYCORE_CREDIT_HOLD_ASSERT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module manycore_credit_hold_unit #(
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16,
  parameter int init_val_p        = max_out_credits_p,
  parameter int max_step_p        = 1,
  localparam int ctr_width_lp     = $clog2(max_out_credits_p + 1),
  localparam int step_width_lp    = $clog2(max_step_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [step_width_lp-1:0] down_i,
  input  logic [step_width_lp-1:0] up_i,
  output logic [ctr_width_lp-1:0]  out_credits_o,
  output logic                     credits_avail_o,
  output logic                     ctr_err_o,
  input  logic                     v_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic                     hold_i,
  output logic                     v_o,
  output logic [data_width_p-1:0]  data_o
);

  localparam int c_sum_w = ctr_width_lp + step_width_lp + 1;
  localparam logic signed [c_sum_w-1:0]  c_max_sum  = c_sum_w'(max_out_credits_p);
  localparam logic [ctr_width_lp-1:0]    c_max_ctr  = ctr_width_lp'(max_out_credits_p);
  localparam logic [ctr_width_lp-1:0]    c_init_ctr = ctr_width_lp'(init_val_p);

  logic [ctr_width_lp-1:0]    r_count;
  logic                       r_err;
  logic signed [c_sum_w-1:0]  w_next;
  logic                       w_under;
  logic                       w_over;

  // The extra sign bit lets a too-large decrement show up as a negative value.
  always_comb begin
    w_next  = $signed({{(c_sum_w - ctr_width_lp){1'b0}}, r_count})
            + $signed({{(c_sum_w - step_width_lp){1'b0}}, up_i})
            - $signed({{(c_sum_w - step_width_lp){1'b0}}, down_i});
    w_under = w_next[c_sum_w-1];
    w_over  = !w_under && (w_next > c_max_sum);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= c_init_ctr;
      r_err   <= 1'b0;
    end else if (w_under) begin
      r_count <= '0;
      r_err   <= 1'b1;
    end else if (w_over) begin
      r_count <= c_max_ctr;
      r_err   <= 1'b1;
    end else begin
      r_count <= w_next[ctr_width_lp-1:0];
      r_err   <= 1'b0;
    end
  end

  assign out_credits_o   = r_count;
  assign credits_avail_o = (r_count != '0);
  assign ctr_err_o       = r_err;

  logic                    r_hold;
  logic                    r_v;
  logic [data_width_p-1:0] r_data;

  // Capture keeps running until the first held cycle, so the frozen word is
  // the one seen in the cycle hold_i rose.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hold <= 1'b0;
      r_v    <= 1'b0;
      r_data <= '0;
    end else begin
      r_hold <= hold_i;
      if (!r_hold) begin
        r_v    <= v_i;
        r_data <= data_i;
      end
    end
  end

  assign v_o    = r_hold ? r_v    : v_i;
  assign data_o = r_hold ? r_data : data_i;

`ifdef MANYCORE_CREDIT_HOLD_ASSERT_EN
  logic r_zero_seen;

  always @(negedge clk_i) begin
    if (reset_i) begin
      r_zero_seen <= 1'b0;
    end else begin
      if (w_under || w_over) begin
        $error("manycore_credit_hold_unit: credit counter saturation attempt");
        $finish;
      end
      if (int'(up_i) > max_step_p || int'(down_i) > max_step_p)
        $error("manycore_credit_hold_unit: step exceeds max_step_p");
      if (r_count == '0 && !r_zero_seen) begin
        $display("manycore_credit_hold_unit: warning, credits exhausted");
        r_zero_seen <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_manycore_credit_hold_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_manycore_credit_hold_unit
// Brief   : Self-checking bench for manycore_credit_hold_unit (4 credits).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_manycore_credit_hold_unit;

  localparam int c_max = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [0:0]  down_i, up_i;
  logic [2:0]  out_credits_o;
  logic        credits_avail_o, ctr_err_o;
  logic        v_i, hold_i, v_o;
  logic [31:0] data_i, data_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: credit count, error flag, and what the return path
  // would be showing if it were frozen right now.
  int          m_count;
  bit          m_err;
  bit          m_frozen;
  bit          m_fv;
  logic [31:0] m_fd;

  manycore_credit_hold_unit #(
    .data_width_p(32), .max_out_credits_p(c_max), .init_val_p(c_max), .max_step_p(1)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .down_i(down_i), .up_i(up_i),
    .out_credits_o(out_credits_o), .credits_avail_o(credits_avail_o),
    .ctr_err_o(ctr_err_o), .v_i(v_i), .data_i(data_i), .hold_i(hold_i),
    .v_o(v_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input bit rst, input bit up, input bit dn,
                       input bit v, input logic [31:0] d, input bit hold);
    reset_i = rst; up_i = up; down_i = dn; v_i = v; data_i = d; hold_i = hold;
  endtask

  // Advance one clock and update the reference from the inputs just applied.
  task automatic advance();
    int n;
    @(posedge clk_i);
    if (reset_i) begin
      m_count = c_max; m_err = 0; m_frozen = 0; m_fv = 0; m_fd = '0;
    end else begin
      n = m_count + int'(up_i) - int'(down_i);
      if (n < 0)          begin m_count = 0;     m_err = 1; end
      else if (n > c_max) begin m_count = c_max; m_err = 1; end
      else                begin m_count = n;     m_err = 0; end
      if (!m_frozen) begin m_fv = v_i; m_fd = data_i; end
      m_frozen = hold_i;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 32'h1234_5678, 0);
    advance(); advance();
    drive(0, 0, 0, 1, 32'h1234_5678, 0);
    @(negedge clk_i);
    vectors++;
    if (out_credits_o !== 3'd4) begin miscompares++;
      $display("FAIL reset_count got %0d want 4", out_credits_o); end
    vectors++;
    if (credits_avail_o !== 1'b1 || ctr_err_o !== 1'b0) begin miscompares++;
      $display("FAIL reset_flags got avail=%b err=%b want 1 0", credits_avail_o, ctr_err_o); end
    vectors++;
    if (v_o !== 1'b1 || data_o !== 32'h1234_5678) begin miscompares++;
      $display("FAIL reset_pass got v=%b d=%h want 1 12345678", v_o, data_o); end
    #1;
  endtask

  task automatic test_count_down();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 32'h0, 0);
      advance();
      @(negedge clk_i);
      vectors++;
      if (out_credits_o !== 3'((i < 4) ? 3 - i : 0)) begin miscompares++;
        $display("FAIL down_count step %0d got %0d want %0d", i, out_credits_o, (i < 4) ? 3 - i : 0); end
      vectors++;
      if (credits_avail_o !== (i < 3) || ctr_err_o !== (i == 4)) begin miscompares++;
        $display("FAIL down_flags step %0d got avail=%b err=%b want %b %b",
                 i, credits_avail_o, ctr_err_o, i < 3, i == 4); end
      #1;
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    advance();
    @(negedge clk_i);
    vectors++;
    if (ctr_err_o !== 1'b0) begin miscompares++;
      $display("FAIL err_clears got %b want 0", ctr_err_o); end
    #1;
  endtask

  task automatic test_up_overflow();
    bit [2:0] exp_c [6] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
    bit       exp_e [6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i == 2), 0, 32'h0, 0);
      advance();
      @(negedge clk_i);
      vectors++;
      if (out_credits_o !== exp_c[i] || ctr_err_o !== exp_e[i]) begin miscompares++;
        $display("FAIL up_count step %0d got %0d err=%b want %0d err=%b",
                 i, out_credits_o, ctr_err_o, exp_c[i], exp_e[i]); end
      #1;
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    advance();
  endtask

  task automatic test_hold();
    logic [31:0] exp_d [5] = '{32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0000_FFFF};
    bit          exp_v [5] = '{1, 1, 1, 1, 0};
    drive(0, 0, 0, 0, 32'h0, 0);
    advance();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(0, 0, 0, 1, 32'hA5A5_0001, 1);
      else        drive(0, 0, 0, 0, 32'h0000_FFFF, (i < 3));
      @(negedge clk_i);
      vectors++;
      if (v_o !== exp_v[i] || data_o !== exp_d[i]) begin miscompares++;
        $display("FAIL hold cycle t+%0d got v=%b d=%h want v=%b d=%h",
                 i, v_o, data_o, exp_v[i], exp_d[i]); end
      advance();
    end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1'($urandom), $urandom, 0);
      @(negedge clk_i);
      vectors++;
      if (v_o !== v_i || data_o !== data_i) begin miscompares++;
        $display("FAIL pass_through %0d got v=%b d=%h want v=%b d=%h", i, v_o, data_o, v_i, data_i); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, ($urandom_range(0, 2) == 0));
      @(negedge clk_i);
      vectors++;
      if (out_credits_o !== 3'(m_count) || ctr_err_o !== m_err ||
          credits_avail_o !== (m_count != 0)) begin miscompares++;
        $display("FAIL rand_ctr %0d got %0d err=%b avail=%b want %0d err=%b",
                 i, out_credits_o, ctr_err_o, credits_avail_o, m_count, m_err); end
      vectors++;
      if (v_o !== (m_frozen ? m_fv : v_i) || data_o !== (m_frozen ? m_fd : data_i)) begin
        miscompares++;
        $display("FAIL rand_hold %0d got v=%b d=%h want v=%b d=%h", i, v_o, data_o,
                 m_frozen ? m_fv : v_i, m_frozen ? m_fd : data_i); end
      advance();
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
    advance();
    drive(0, 0, 1, 0, 32'h1111_1111, 1);
    @(negedge clk_i);
    vectors++;
    if (v_o !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL mid_hold_frozen got v=%b d=%h want 1 deadbeef", v_o, data_o); end
    advance();
    drive(1, 0, 0, 0, 32'h2222_2222, 1);
    advance();
    drive(0, 0, 0, 0, 32'h3333_3333, 0);
    @(negedge clk_i);
    vectors++;
    if (v_o !== 1'b0 || data_o !== 32'h3333_3333) begin miscompares++;
      $display("FAIL after_reset_pass got v=%b d=%h want 0 33333333", v_o, data_o); end
    vectors++;
    if (out_credits_o !== 3'd4 || ctr_err_o !== 1'b0) begin miscompares++;
      $display("FAIL after_reset_count got %0d err=%b want 4 0", out_credits_o, ctr_err_o); end
    advance();
  endtask

  initial begin
    m_count = c_max; m_err = 0; m_frozen = 0; m_fv = 0; m_fd = '0;
    test_reset();
    test_count_down();
    test_up_overflow();
    test_hold();
    test_pass_through();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/manycore_credit_hold_unit.md
Name: manycore_credit_hold_unit

Overview:
- Credit and return-path helper for a manycore network endpoint.
- Combines two functions:
  - an up/down outgoing-credit counter: decremented on packet launch, incremented on credit return.
  - a one-cycle hold stage that freezes returning read data while the return network is back-pressured.
- Sits between the tile's memory/return logic and the endpoint's return FIFO.

Parameters:
- data_width_p, 32, width of returning data word.
- max_out_credits_p, 16, maximum credit count (must be ≥1).
- init_val_p, max_out_credits_p, counter value loaded on reset (0..max_out_credits_p).
- max_step_p, 1, largest per-cycle increment or decrement (≥1).
- Derived: ctr_width_lp = $clog2(max_out_credits_p+1); step_width_lp = $clog2(max_step_p+1).

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- down_i  in  step_width_lp  credits consumed this cycle (packet launches).
- up_i  in  step_width_lp  credits returned this cycle.
- out_credits_o  out  ctr_width_lp  current credit count, registered.
- credits_avail_o  out  1  out_credits_o != 0.
- ctr_err_o  out  1  registered pulse: last cycle's update would have under- or overflowed.
- v_i  in  1  returning data valid.
- data_i  in  data_width_p  returning data.
- hold_i  in  1  back-pressure: freeze the output next cycle.
- v_o  out  1  held/passed valid.
- data_o  out  data_width_p  held/passed data.

Behaviour:
Counter:
- Reset: count = init_val_p; ctr_err_o = 0.
- Each cycle: next = count + up_i − down_i, computed at width ctr_width_lp+step_width_lp+1, signed.
- Simultaneous equal up_i and down_i: count unchanged.
- Underflow (next < 0): count ← 0; ctr_err_o = 1 next cycle.
- Overflow (next > max_out_credits_p): count ← max_out_credits_p; ctr_err_o = 1 next cycle.
- Otherwise: count ← next; ctr_err_o = 0.
- up_i or down_i > max_step_p is illegal; it is treated as the raw value, and the saturation rules still apply.
- credits_avail_o is combinational from the register.

Hold stage:
- Registers: hold_r, v_r, data_r.
- Reset: hold_r = 0, v_r = 0, data_r = 0.
- Every cycle: hold_r ← hold_i.
- When hold_r = 0: v_r ← v_i and data_r ← data_i (capture every cycle). When hold_r = 1: v_r and data_r retain their values.
- Outputs: v_o = hold_r ? v_r : v_i; data_o = hold_r ? data_r : data_i.
- Effect: when hold_i rises in cycle t, outputs pass through in t. From t+1 until the cycle after hold_i falls, outputs show the values sampled in cycle t.
- Zero latency when not holding.
- Back-to-back holds of any length keep the same captured value.
- hold_i deasserted in cycle u: outputs return to pass-through in u+1, and capture resumes in u+1.
- Reset mid-hold: clears hold_r/v_r, so v_o follows v_i the cycle after reset.
- The counter and the hold stage are independent; the only shared signals are clk_i and reset_i.

Optional Feature:
- Macro: MANYCORE_CREDIT_HOLD_ASSERT_EN.
- Defined, simulation-only checks on negedge clk_i with reset_i low:
  - $error plus $finish on any underflow/overflow attempt.
  - $error if up_i or down_i > max_step_p.
  - $display warning the first time count reaches 0.
- Not defined: no checks compiled; saturation and ctr_err_o behave identically either way (no RTL behaviour change).

Test Plan:
- Reset with max_out_credits_p=4 → out_credits_o=4, credits_avail_o=1, v_o follows v_i, ctr_err_o=0.
- Four cycles down_i=1 → count 3,2,1,0 and credits_avail_o=0. Then a 5th down_i=1 → count stays 0, ctr_err_o=1 one cycle later.
- Same cycle up_i=1, down_i=1 at count 2 → stays 2. Then up_i=1 three times → 3, 4, 4, with ctr_err_o=1 after the third.
- v_i=1, data_i=0xA5A5_0001 with hold_i=1 in cycle t; cycles t+1..t+3 drive data_i=0x0000_FFFF, v_i=0, with hold_i=1 through t+2 and 0 at t+3:
  - data_o=0xA5A5_0001, v_o=1 in t..t+3.
  - Pass-through (0x0000_FFFF) in t+4.
- hold_i=0 throughout with random v_i/data_i → v_o/data_o equal to inputs combinationally every cycle.
- Assert reset_i during an active hold → next cycle hold_r=0, v_o=v_i, and count reloads to init_val_p.
